// File: rtl/ex_flag_stage.sv
// ex_flag_stage: EX->MEM pipeline register placed right after the 32-bit add/sub unit.
// Latches the adder result and its N/C/V outputs behind a valid/ready handshake, derives Z,
// keeps the architectural NZCV register and turns signed overflow into a precise exception
// (write-back suppressed, PC captured into EPC, intake stalled until the handler acks).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready EX-side handshake
//   alu_*             adder result and flags, alu_signed marks a signed add/sub
//   flag_we           op updates NZCV
//   in_pc/in_rd/in_wen op PC, destination index, register-file write enable
//   flush             kills the held entry and the incoming op
//   out_*             MEM-side handshake and latched entry
//   flags             {N,Z,C,V}
//   exc_req/exc_epc   one-cycle overflow exception pulse and faulting PC
//   exc_ack           handler has redirected fetch; releases the stall
module ex_flag_stage #(
    parameter int unsigned RD_W     = 5,
    parameter logic [3:0]  FLAG_RST = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     alu_c,
    input  logic            alu_overflow,
    input  logic            alu_carry,
    input  logic            alu_negative,
    input  logic            alu_signed,
    input  logic            flag_we,
    input  logic [31:0]     in_pc,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_wen,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic [3:0]      flags,
    output logic            exc_req,
    output logic [31:0]     exc_epc,
    input  logic            exc_ack
);

    typedef enum logic [0:0] {StRun, StExcWait} state_e;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [31:0]       result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wen_q, wen_d;
    logic [3:0]        flags_q, flags_d;
    logic              exc_req_q, exc_req_d;
    logic [31:0]       epc_q, epc_d;

    logic ovf;
    logic accept;

    // Overflow only matters for signed ops; the unsigned path ignores a glitching flag.
    assign ovf      = alu_signed & alu_overflow;
    assign in_ready = (state_q == StRun) & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        flags_d   = flags_q;
        exc_req_d = 1'b0;
        epc_d     = epc_q;

        // Ack only leaves EXC_WAIT; in RUN it is ignored.
        if (state_q == StExcWait && exc_ack) begin
            state_d = StRun;
        end

        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = ovf ? 32'd0 : alu_c;
            rd_d     = in_rd;
            wen_d    = in_wen & ~ovf;
            if (ovf) begin
                exc_req_d = 1'b1;
                epc_d     = in_pc;
                state_d   = StExcWait;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        // The adder zeroes its result on overflow, so Z is masked to avoid a false zero.
        if (accept && flag_we) begin
            flags_d = {alu_negative, (alu_c == 32'd0) & ~ovf, alu_carry, alu_overflow};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            valid_q   <= 1'b0;
            result_q  <= 32'd0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            flags_q   <= FLAG_RST;
            exc_req_q <= 1'b0;
            epc_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            flags_q   <= flags_d;
            exc_req_q <= exc_req_d;
            epc_q     <= epc_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_wen    = wen_q;
    assign flags      = flags_q;
    assign exc_req    = exc_req_q;
    assign exc_epc    = epc_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
module tb_ex_flag_stage;

    localparam logic [3:0] FLAG_RST = 4'b1010;

    logic        clk, rst, in_valid, in_ready;
    logic [31:0] alu_c;
    logic        alu_overflow, alu_carry, alu_negative, alu_signed, flag_we;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_wen, flush, out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [3:0]  flags;
    logic        exc_req;
    logic [31:0] exc_epc;
    logic        exc_ack;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: expected visible state, advanced once per clock edge.
    logic        m_valid, m_wen, m_exc_req, m_wait;
    logic [31:0] m_result, m_epc;
    logic [4:0]  m_rd;
    logic [3:0]  m_flags;

    ex_flag_stage #(
        .RD_W     (5),
        .FLAG_RST (FLAG_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_c        (alu_c),
        .alu_overflow (alu_overflow),
        .alu_carry    (alu_carry),
        .alu_negative (alu_negative),
        .alu_signed   (alu_signed),
        .flag_we      (flag_we),
        .in_pc        (in_pc),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wen      (out_wen),
        .flags        (flags),
        .exc_req      (exc_req),
        .exc_epc      (exc_epc),
        .exc_ack      (exc_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_ready();
        return !m_wait && (!m_valid || out_ready);
    endfunction

    task automatic model_update();
        logic acc, ovf;
        acc = in_valid && m_ready() && !flush;
        ovf = alu_signed && alu_overflow;
        if (rst) begin
            m_valid = 0; m_result = 0; m_rd = 0; m_wen = 0;
            m_flags = FLAG_RST; m_exc_req = 0; m_epc = 0; m_wait = 0;
        end else begin
            m_exc_req = 0;
            if (m_wait && exc_ack) m_wait = 0;
            if (acc && flag_we)
                m_flags = {alu_negative, (alu_c == 0) && !ovf, alu_carry, alu_overflow};
            if (flush) begin
                m_valid = 0;
                m_wen   = 0;
            end else if (acc) begin
                m_valid  = 1;
                m_result = ovf ? 32'd0 : alu_c;
                m_rd     = in_rd;
                m_wen    = in_wen && !ovf;
                if (ovf) begin
                    m_exc_req = 1;
                    m_epc     = in_pc;
                    m_wait    = 1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; in_valid = 0; alu_c = 0; alu_overflow = 0; alu_carry = 0;
        alu_negative = 0; alu_signed = 0; flag_we = 0; in_pc = 0; in_rd = 0;
        in_wen = 0; flush = 0; out_ready = 1; exc_ack = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %h want 0", out_valid); else n_pass++;
        n_chk++; if (out_result !== 32'd0) $display("FAIL rst_result: got %h want 0", out_result); else n_pass++;
        n_chk++; if (out_wen !== 1'b0) $display("FAIL rst_wen: got %h want 0", out_wen); else n_pass++;
        n_chk++; if (flags !== FLAG_RST) $display("FAIL rst_flags: got %b want %b", flags, FLAG_RST); else n_pass++;
        n_chk++; if (exc_req !== 1'b0) $display("FAIL rst_exc_req: got %h want 0", exc_req); else n_pass++;
        n_chk++; if (exc_epc !== 32'd0) $display("FAIL rst_epc: got %h want 0", exc_epc); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %h want 1", in_ready); else n_pass++;
    endtask

    task automatic test_unsigned_wrap();
        idle();
        in_valid = 1; alu_c = 32'h0; alu_carry = 1; flag_we = 1; in_wen = 1; in_rd = 5'd3;
        tick();
        n_chk++; if (out_valid !== 1'b1) $display("FAIL uw_valid: got %h want 1", out_valid); else n_pass++;
        n_chk++; if (out_result !== 32'd0) $display("FAIL uw_result: got %h want 0", out_result); else n_pass++;
        n_chk++; if (out_wen !== 1'b1) $display("FAIL uw_wen: got %h want 1", out_wen); else n_pass++;
        n_chk++; if (out_rd !== 5'd3) $display("FAIL uw_rd: got %h want 3", out_rd); else n_pass++;
        n_chk++; if (flags !== 4'b0110) $display("FAIL uw_flags: got %b want 0110", flags); else n_pass++;
        n_chk++; if (exc_req !== 1'b0) $display("FAIL uw_exc: got %h want 0", exc_req); else n_pass++;
        // Overflow glitch on the unsigned path must not raise an exception.
        idle();
        in_valid = 1; alu_c = 32'h1234; alu_overflow = 1; in_wen = 1;
        tick();
        n_chk++; if (exc_req !== 1'b0) $display("FAIL uglitch_exc: got %h want 0", exc_req); else n_pass++;
        n_chk++; if (out_wen !== 1'b1) $display("FAIL uglitch_wen: got %h want 1", out_wen); else n_pass++;
        n_chk++; if (out_result !== 32'h1234) $display("FAIL uglitch_result: got %h want 1234", out_result); else n_pass++;
        n_chk++; if (flags !== 4'b0110) $display("FAIL uglitch_flags: got %b want 0110", flags); else n_pass++;
    endtask

    task automatic test_overflow();
        idle();
        in_valid = 1; alu_signed = 1; alu_overflow = 1; alu_c = 0; flag_we = 1; in_wen = 1;
        in_pc = 32'h0040_0010; in_rd = 5'd7;
        tick();
        n_chk++; if (exc_req !== 1'b1) $display("FAIL ovf_exc: got %h want 1", exc_req); else n_pass++;
        n_chk++; if (exc_epc !== 32'h0040_0010) $display("FAIL ovf_epc: got %h want 00400010", exc_epc); else n_pass++;
        n_chk++; if (out_wen !== 1'b0) $display("FAIL ovf_wen: got %h want 0", out_wen); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %h want 1", out_valid); else n_pass++;
        n_chk++; if (flags !== 4'b0001) $display("FAIL ovf_flags: got %b want 0001", flags); else n_pass++;
        idle();
        in_valid = 1; alu_c = 32'd7; in_wen = 1;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL ovf_stall: got %h want 0", in_ready); else n_pass++;
        tick();
        n_chk++; if (exc_req !== 1'b0) $display("FAIL ovf_pulse: got %h want 0", exc_req); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL ovf_drain: got %h want 0", out_valid); else n_pass++;
        exc_ack = 1;
        #1;
        n_chk++; if (in_ready !== 1'b0) $display("FAIL ack_cycle_ready: got %h want 0", in_ready); else n_pass++;
        tick();
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL post_ack_ready: got %h want 1", in_ready); else n_pass++;
        // exc_ack still high now, in RUN: must be ignored and the op accepted normally.
        tick();
        exc_ack = 0;
        n_chk++; if (out_result !== 32'd7) $display("FAIL post_ack_result: got %h want 7", out_result); else n_pass++;
        n_chk++; if (exc_epc !== 32'h0040_0010) $display("FAIL epc_hold: got %h want 00400010", exc_epc); else n_pass++;
        n_chk++; if (exc_req !== 1'b0) $display("FAIL post_ack_exc: got %h want 0", exc_req); else n_pass++;
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1; alu_c = 32'h11; in_wen = 1;
        tick();
        out_ready = 0; alu_c = 32'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %h want 0", i, in_ready); else n_pass++;
            tick();
            n_chk++; if (out_result !== 32'h11) $display("FAIL bp_hold%0d: got %h want 11", i, out_result); else n_pass++;
            n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_valid%0d: got %h want 1", i, out_valid); else n_pass++;
        end
        out_ready = 1;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %h want 1", in_ready); else n_pass++;
        tick();
        n_chk++; if (out_result !== 32'h22) $display("FAIL bp_next: got %h want 22", out_result); else n_pass++;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_nobubble: got %h want 1", out_valid); else n_pass++;
        idle();
        tick();
    endtask

    task automatic test_flush_ovf();
        idle();
        in_valid = 1; alu_c = 32'h8000_0001; alu_negative = 1; flag_we = 1; in_wen = 1;
        tick();
        out_ready = 0;
        in_valid = 1; alu_signed = 1; alu_overflow = 1; alu_c = 0; alu_negative = 0;
        in_pc = 32'h0000_0BAD; flush = 1;
        tick();
        idle();
        n_chk++; if (out_valid !== 1'b0) $display("FAIL fl_valid: got %h want 0", out_valid); else n_pass++;
        n_chk++; if (out_wen !== 1'b0) $display("FAIL fl_wen: got %h want 0", out_wen); else n_pass++;
        n_chk++; if (exc_req !== 1'b0) $display("FAIL fl_exc: got %h want 0", exc_req); else n_pass++;
        n_chk++; if (flags !== 4'b1000) $display("FAIL fl_flags: got %b want 1000", flags); else n_pass++;
        n_chk++; if (exc_epc !== 32'h0040_0010) $display("FAIL fl_epc: got %h want 00400010", exc_epc); else n_pass++;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL fl_state: got %h want 1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        idle();
        in_valid = 1; alu_c = 32'h8000_0000; alu_negative = 1; flag_we = 1; in_wen = 1;
        tick();
        n_chk++; if (flags !== 4'b1000) $display("FAIL b2b_flags1: got %b want 1000", flags); else n_pass++;
        alu_c = 32'd5; alu_negative = 0; flag_we = 0;
        tick();
        idle();
        n_chk++; if (flags !== 4'b1000) $display("FAIL b2b_flags2: got %b want 1000", flags); else n_pass++;
        n_chk++; if (out_result !== 32'd5) $display("FAIL b2b_result: got %h want 5", out_result); else n_pass++;
    endtask

    task automatic test_rst_in_exc();
        idle();
        in_valid = 1; alu_signed = 1; alu_overflow = 1; in_pc = 32'hDEAD_0000;
        tick();
        idle();
        n_chk++; if (exc_epc !== 32'hDEAD_0000) $display("FAIL rx_epc_set: got %h want dead0000", exc_epc); else n_pass++;
        rst = 1;
        tick();
        rst = 0; out_ready = 0;
        #1;
        n_chk++; if (in_ready !== 1'b1) $display("FAIL rx_ready: got %h want 1", in_ready); else n_pass++;
        n_chk++; if (flags !== FLAG_RST) $display("FAIL rx_flags: got %b want %b", flags, FLAG_RST); else n_pass++;
        n_chk++; if (exc_epc !== 32'd0) $display("FAIL rx_epc: got %h want 0", exc_epc); else n_pass++;
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 79) == 0);
            in_valid     = ($urandom_range(0, 3) != 0);
            alu_c        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            alu_signed   = ($urandom_range(0, 1) == 0);
            alu_overflow = ($urandom_range(0, 5) == 0);
            alu_carry    = ($urandom_range(0, 1) == 0);
            alu_negative = ($urandom_range(0, 1) == 0);
            flag_we      = ($urandom_range(0, 1) == 0);
            in_pc        = $urandom();
            in_rd        = 5'($urandom());
            in_wen       = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 9) == 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            exc_ack      = ($urandom_range(0, 3) == 0);
            #1;
            n_chk++; if (in_ready !== m_ready()) $display("FAIL rnd_ready@%0d: got %h want %h", i, in_ready, m_ready()); else n_pass++;
            tick();
            n_chk++; if (out_valid !== m_valid) $display("FAIL rnd_valid@%0d: got %h want %h", i, out_valid, m_valid); else n_pass++;
            n_chk++; if (out_result !== m_result) $display("FAIL rnd_result@%0d: got %h want %h", i, out_result, m_result); else n_pass++;
            n_chk++; if (out_rd !== m_rd) $display("FAIL rnd_rd@%0d: got %h want %h", i, out_rd, m_rd); else n_pass++;
            n_chk++; if (out_wen !== m_wen) $display("FAIL rnd_wen@%0d: got %h want %h", i, out_wen, m_wen); else n_pass++;
            n_chk++; if (flags !== m_flags) $display("FAIL rnd_flags@%0d: got %b want %b", i, flags, m_flags); else n_pass++;
            n_chk++; if (exc_req !== m_exc_req) $display("FAIL rnd_exc@%0d: got %h want %h", i, exc_req, m_exc_req); else n_pass++;
            n_chk++; if (exc_epc !== m_epc) $display("FAIL rnd_epc@%0d: got %h want %h", i, exc_epc, m_epc); else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_unsigned_wrap();
        test_overflow();
        test_backpressure();
        test_flush_ovf();
        test_back_to_back();
        test_rst_in_exc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
